heu_window_eq: RTL and testbench



---
 rtl/heu_window_eq.sv | 191 +++++++++++++++++++
 tb/tb_heu_window_eq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/heu_window_eq.sv
// heu_window_eq -- histogram-equalization unit for one 20x20 8-bit window.
//
// Accepts a window from the IPGU (vldIpgu/rdyHeu), builds its 256-bin
// histogram, turns the bins into a cumulative distribution in place, then
// remaps every pixel through (cdf*SCALE_MUL)>>16 and presents the result
// to the next stage (vldHeu/rdyRnn). One window in flight at a time.
//
// Ports
//   clk            system clock
//   rst_n          synchronous active-low reset
//   vldIpgu        input window valid
//   ipguOutBufferQ input window, pixel (y,x) at [y/4][(y%4)*20+x]
//   rdyHeu         ready to accept a window
//   vldHeu         equalized window valid
//   heuOutBufferQ  equalized window, same packing as the input
//   rdyRnn         downstream ready
//   winCnt         (HEU_WIN_CNT_EN only) count of completed output handshakes
//
// Optional feature macro: HEU_WIN_CNT_EN
//
// Latency: vldHeu rises 256+400+256+400 = 1312 edges after the accept edge.

module heu_window_eq #(
  parameter int DATA_WIDTH = 8,
  parameter int WIN_PIX    = 400,
  parameter int NUM_BINS   = 256,
  parameter int SCALE_MUL  = 41780
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 vldIpgu,
  input  logic [4:0][79:0][DATA_WIDTH-1:0]     ipguOutBufferQ,
  output logic                                 rdyHeu,
  output logic                                 vldHeu,
  output logic [4:0][79:0][DATA_WIDTH-1:0]     heuOutBufferQ,
`ifdef HEU_WIN_CNT_EN
  output logic [15:0]                          winCnt,
`endif
  input  logic                                 rdyRnn
);

  localparam int PW = WIN_PIX * DATA_WIDTH;
  localparam int IW = $clog2(PW);
  localparam logic [8:0]  LAST_BIN = 9'(NUM_BINS - 1);
  localparam logic [8:0]  LAST_PIX = 9'(WIN_PIX - 1);
  localparam logic [15:0] SCALE_C  = 16'(SCALE_MUL);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_HIST, S_CDF, S_MAP, S_OUT
  } state_t;

  state_t          state_q, state_d;
  logic [8:0]      cnt_q, cnt_d;
  logic [8:0]      acc_q, acc_d;
  logic            rdy_q, rdy_d;
  logic            vld_q, vld_d;
  logic [PW-1:0]   pix_q, pix_d;
  logic [PW-1:0]   out_q, out_d;
  logic [8:0]      bin_q [NUM_BINS];
  logic [8:0]      bin_d [NUM_BINS];

  logic [IW-1:0]   bit_idx;
  logic [DATA_WIDTH-1:0] cur_pix;
  logic [8:0]      cdf_sum;
  logic [24:0]     prod;
  logic [7:0]      map_val;

  // The packing rule [y/4][(y%4)*20+x] with k=y*20+x collapses to
  // [k/80][k%80], i.e. pixel k sits at flat bit offset k*8.
  always_comb begin
    bit_idx = IW'(cnt_q * DATA_WIDTH);
    cur_pix = pix_q[bit_idx +: DATA_WIDTH];
    cdf_sum = acc_q + bin_q[cnt_q[7:0]];
    prod    = {16'd0, bin_q[cur_pix]} * {9'd0, SCALE_C};
    map_val = prod[24] ? 8'hFF : prod[23:16];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rdy_d   = rdy_q;
    vld_d   = vld_q;
    pix_d   = pix_q;
    out_d   = out_q;
    bin_d   = bin_q;
    case (state_q)
      S_IDLE: begin
        if (rdy_q && vldIpgu) begin
          pix_d   = ipguOutBufferQ;
          rdy_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_CLR;
        end else begin
          rdy_d = 1'b1;   // first edge out of reset raises ready
        end
      end
      S_CLR: begin
        bin_d[cnt_q[7:0]] = '0;
        if (cnt_q == LAST_BIN) begin
          cnt_d   = '0;
          state_d = S_HIST;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      S_HIST: begin
        bin_d[cur_pix] = bin_q[cur_pix] + 9'd1;
        if (cnt_q == LAST_PIX) begin
          cnt_d   = '0;
          acc_d   = '0;
          state_d = S_CDF;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      S_CDF: begin
        // running sum written back over the histogram bin
        bin_d[cnt_q[7:0]] = cdf_sum;
        acc_d             = cdf_sum;
        if (cnt_q == LAST_BIN) begin
          cnt_d   = '0;
          state_d = S_MAP;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      S_MAP: begin
        out_d[bit_idx +: DATA_WIDTH] = map_val;
        if (cnt_q == LAST_PIX) begin
          cnt_d   = '0;
          vld_d   = 1'b1;
          state_d = S_OUT;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      S_OUT: begin
        if (rdyRnn) begin
          vld_d   = 1'b0;
          rdy_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      pix_q   <= '0;
      out_q   <= '0;
      for (int i = 0; i < NUM_BINS; i++) bin_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      pix_q   <= pix_d;
      out_q   <= out_d;
      for (int i = 0; i < NUM_BINS; i++) bin_q[i] <= bin_d[i];
    end
  end

  assign rdyHeu        = rdy_q;
  assign vldHeu        = vld_q;
  assign heuOutBufferQ = out_q;

`ifdef HEU_WIN_CNT_EN
  logic [15:0] wcnt_q, wcnt_d;

  always_comb begin
    wcnt_d = wcnt_q;
    if (vld_q && rdyRnn) wcnt_d = wcnt_q + 16'd1;   // wraps naturally
  end

  always_ff @(posedge clk) begin
    if (!rst_n) wcnt_q <= '0;
    else        wcnt_q <= wcnt_d;
  end

  assign winCnt = wcnt_q;
`endif

endmodule

// File: tb/tb_heu_window_eq.sv
module tb_heu_window_eq;

  typedef logic [4:0][79:0][7:0] win_t;

  logic clk = 1'b0;
  logic rst_n, vldIpgu, rdyHeu, vldHeu, rdyRnn;
  win_t ipguOutBufferQ, heuOutBufferQ;
`ifdef HEU_WIN_CNT_EN
  logic [15:0] winCnt;
`endif

  int vectors    = 0;
  int miscompares = 0;
  int hs_count   = 0;
  win_t last_out;

  always #5 clk = ~clk;

  heu_window_eq dut (
    .clk(clk), .rst_n(rst_n), .vldIpgu(vldIpgu), .ipguOutBufferQ(ipguOutBufferQ),
    .rdyHeu(rdyHeu), .vldHeu(vldHeu), .heuOutBufferQ(heuOutBufferQ),
`ifdef HEU_WIN_CNT_EN
    .winCnt(winCnt),
`endif
    .rdyRnn(rdyRnn)
  );

  // Reference: histogram over (y,x), cumulative sum, scale, saturate.
  function automatic win_t model(input win_t w);
    int hist [256];
    int cdf  [256];
    int acc, v;
    win_t o;
    for (int i = 0; i < 256; i++) hist[i] = 0;
    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 20; x++)
        hist[w[y/4][(y%4)*20+x]]++;
    acc = 0;
    for (int i = 0; i < 256; i++) begin
      acc += hist[i];
      cdf[i] = acc;
    end
    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 20; x++) begin
        v = (cdf[w[y/4][(y%4)*20+x]] * 41780) / 65536;
        if (v > 255) v = 255;
        o[y/4][(y%4)*20+x] = 8'(v);
      end
    return o;
  endfunction

  function automatic win_t rand_win(input int lo, input int hi);
    win_t w;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 80; c++)
        w[r][c] = 8'($urandom_range(hi, lo));
    return w;
  endfunction

  function automatic win_t by_k(input int mode);
    win_t w;
    int k;
    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 20; x++) begin
        k = y*20 + x;
        case (mode)
          0:       w[y/4][(y%4)*20+x] = 8'(k/4);
          default: w[y/4][(y%4)*20+x] = (k % 2 == 0) ? 8'd0 : 8'd255;
        endcase
      end
    return w;
  endfunction

  function automatic win_t flat(input int v);
    win_t w;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 80; c++) w[r][c] = 8'(v);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_win(input string tag, input win_t obs, input win_t exp);
    int fr, fc;
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      fr = 0; fc = 0;
      for (int r = 4; r >= 0; r--)
        for (int c = 79; c >= 0; c--)
          if (obs[r][c] !== exp[r][c]) begin fr = r; fc = c; end
      $error("FAIL %s: pixel[%0d][%0d] observed %0d expected %0d",
             tag, fr, fc, obs[fr][fc], exp[fr][fc]);
    end
  endtask

  // Apply one window, check latency, ready, data, optional backpressure and
  // the closing handshake. Caller is #1 after an edge on entry and exit.
  task automatic run_window(input win_t w, input int bp, input bit hold, input string tag);
    win_t exp, snap;
    int   n;
    bit   rdy_low, stable;
    exp = model(w);
    ipguOutBufferQ = w;
    vldIpgu = 1'b1;
    n = 0;
    while (!rdyHeu && n < 3000) begin @(posedge clk); #1; n++; end
    chk({tag, " rdy_before_accept"}, 32'(rdyHeu), 32'd1);
    if (bp > 0) rdyRnn = 1'b0;
    @(posedge clk); #1;                       // accept edge T
    if (!hold) begin
      vldIpgu = 1'b0;
      ipguOutBufferQ = rand_win(0, 255);
    end
    n = 0;
    rdy_low = 1'b1;
    while (1) begin
      if (rdyHeu) rdy_low = 1'b0;
      if (vldHeu || n >= 1400) break;
      @(posedge clk); #1; n++;
    end
    chk({tag, " latency"}, 32'(n), 32'd1312);
    chk({tag, " rdy_low_while_busy"}, 32'(rdy_low), 32'd1);
    chk_win({tag, " data"}, heuOutBufferQ, exp);
    last_out = heuOutBufferQ;
    if (bp > 0) begin
      snap = heuOutBufferQ;
      stable = 1'b1;
      for (int i = 0; i < bp; i++) begin
        vldIpgu = 1'($urandom_range(1, 0));
        ipguOutBufferQ = rand_win(0, 255);
        @(posedge clk); #1;
        if (!vldHeu || rdyHeu || heuOutBufferQ !== snap) stable = 1'b0;
      end
      vldIpgu = hold;
      chk({tag, " held_under_backpressure"}, 32'(stable), 32'd1);
      rdyRnn = 1'b1;
    end
    @(posedge clk); #1;                       // output handshake edge
    hs_count++;
    chk({tag, " vld_falls"}, 32'(vldHeu), 32'd0);
    chk({tag, " rdy_rises"}, 32'(rdyHeu), 32'd1);
`ifdef HEU_WIN_CNT_EN
    chk({tag, " winCnt"}, 32'(winCnt), 32'(hs_count));
`endif
  endtask

  initial begin
    win_t w;
    int n;
    rst_n = 1'b0;
    vldIpgu = 1'b0;
    rdyRnn = 1'b1;
    ipguOutBufferQ = '0;
    last_out = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset rdyHeu", 32'(rdyHeu), 32'd0);
    chk("reset vldHeu", 32'(vldHeu), 32'd0);
    vectors++;
    assert (heuOutBufferQ === '0) else begin
      miscompares++; $error("FAIL reset out: observed nonzero expected 0");
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rdy after reset", 32'(rdyHeu), 32'd1);

    run_window(flat(100), 0, 1'b0, "flat100");

    run_window(by_k(0), 0, 1'b0, "ramp");
    chk("ramp v0",  32'(last_out[0][0]),  32'd2);
    chk("ramp v49", 32'(last_out[2][36]), 32'd127);
    chk("ramp v99", 32'(last_out[4][76]), 32'd255);

    run_window(by_k(1), 0, 1'b0, "bimodal");
    chk("bimodal zero", 32'(last_out[0][0]), 32'd127);
    chk("bimodal max",  32'(last_out[0][1]), 32'd255);

    run_window(rand_win(0, 255), 0, 1'b0, "rand_full");
    run_window(rand_win(40, 60), 0, 1'b0, "rand_narrow");
    run_window(rand_win(0, 255), 50, 1'b0, "backpressure");

    // abort a window partway through the histogram pass
    ipguOutBufferQ = rand_win(0, 255);
    vldIpgu = 1'b1;
    n = 0;
    while (!rdyHeu && n < 3000) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    vldIpgu = 1'b0;
    repeat (256 + 100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    hs_count = 0;
    chk("abort rdyHeu", 32'(rdyHeu), 32'd0);
    chk("abort vldHeu", 32'(vldHeu), 32'd0);
    vectors++;
    assert (heuOutBufferQ === '0) else begin
      miscompares++; $error("FAIL abort out: observed nonzero expected 0");
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort rdy back", 32'(rdyHeu), 32'd1);
    run_window(flat(50), 0, 1'b0, "flat50_after_abort");

    // back-to-back with vldIpgu held high throughout
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    hs_count = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      w = rand_win(0, 255);
      run_window(w, 0, 1'b1, $sformatf("b2b%0d", i));
    end
    vldIpgu = 1'b0;
    chk("b2b handshakes", 32'(hs_count), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
